// File: rtl/cim_fp_align_accum.sv
// Aligns, signs and accumulates 36 rows of 4-column mantissa products, then normalizes each column sum to FP16.
// Optional build macro CIM_FP_ROUND_EN: round half away from zero on the magnitude (default build truncates).
module cim_fp_align_accum #(
  parameter int MANT_W = 12,
  parameter int ACC_W  = MANT_W + 7
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        diff      [0:35],
  input  logic [3:0]        prod_sign [0:35],
  input  logic [MANT_W-1:0] prod_mant [0:35][0:3],
  input  logic [4:0]        exp_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_fp    [0:3]
);

  localparam int ROWS  = 36;
  localparam int MAG_W = ACC_W - 1;
  localparam int P_W   = $clog2(MAG_W);
`ifdef CIM_FP_ROUND_EN
  localparam int RND_W = 1;
`else
  localparam int RND_W = 0;
`endif
  localparam int WIN_W = 10 + RND_W;

  typedef enum logic [1:0] {IDLE, ACCUM, NORM, HOLD} state_t;

  state_t             state_q;
  logic [5:0]         row_q;
  logic [1:0]         col_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [ACC_W-1:0]   acc_q     [0:3];
  logic [15:0]        out_fp_q  [0:3];

  logic [4:0]         diff_q    [0:ROWS-1];
  logic [3:0]         sign_q    [0:ROWS-1];
  logic [MANT_W-1:0]  mant_q    [0:ROWS-1][0:3];
  logic [4:0]         exp_base_q;

  logic [MANT_W-1:0]  t_al      [0:3];
  logic [ACC_W-1:0]   addend    [0:3];

  logic [ACC_W-1:0]   acc_sel;
  logic               sgn;
  logic [MAG_W-1:0]   mag;
  logic [P_W-1:0]     lead;
  logic [7:0]         e_n;
  logic [WIN_W-1:0]   win;
  logic [9:0]         frac;
  logic [15:0]        fp_d;

  // Operand capture has no reset: contents only matter after an accepted handshake.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      diff_q     <= diff;
      sign_q     <= prod_sign;
      mant_q     <= prod_mant;
      exp_base_q <= exp_base;
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      t_al[c]   = (diff_q[row_q] >= 5'(MANT_W)) ? '0 : (mant_q[row_q][c] >> diff_q[row_q]);
      addend[c] = sign_q[row_q][c] ? ACC_W'(-{{(ACC_W-MANT_W){1'b0}}, t_al[c]})
                                   : {{(ACC_W-MANT_W){1'b0}}, t_al[c]};
    end
  end

  always_comb begin
    acc_sel = acc_q[col_q];
    sgn     = acc_sel[ACC_W-1];
    mag     = sgn ? MAG_W'(-acc_sel) : acc_sel[MAG_W-1:0];
    lead    = '0;
    for (int i = 0; i < MAG_W; i++) begin
      if (mag[i]) lead = P_W'(i);
    end
    e_n = {3'b000, exp_base_q} + 8'(lead) - 8'(MANT_W - 2);
    // Window starts just below the leading one; a short magnitude zero-fills on the right.
    win = WIN_W'({mag, {WIN_W{1'b0}}} >> lead);
`ifdef CIM_FP_ROUND_EN
    frac = win[WIN_W-1:1];
    if (win[0]) begin
      if (&frac) begin
        frac = '0;
        e_n  = e_n + 8'd1;
      end else begin
        frac = frac + 10'd1;
      end
    end
`else
    frac = win;
`endif
    if (mag == '0)                fp_d = 16'h0000;
    else if ($signed(e_n) >= 31)  fp_d = {sgn, 5'h1F, 10'h000};
    else if ($signed(e_n) <= 0)   fp_d = {sgn, 15'h0000};
    else                          fp_d = {sgn, e_n[4:0], frac};
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        acc_q[c]    <= '0;
        out_fp_q[c] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= ACCUM;
            in_ready_q <= 1'b0;
            row_q      <= '0;
            for (int c = 0; c < 4; c++) acc_q[c] <= '0;
          end
        end
        ACCUM: begin
          for (int c = 0; c < 4; c++) acc_q[c] <= acc_q[c] + addend[c];
          if (row_q == 6'(ROWS - 1)) begin
            state_q <= NORM;
            col_q   <= '0;
          end else begin
            row_q <= row_q + 6'd1;
          end
        end
        NORM: begin
          out_fp_q[col_q] <= fp_d;
          if (col_q == 2'd3) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
          end else begin
            col_q <= col_q + 2'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_fp    = out_fp_q;

endmodule

// File: tb/tb_cim_fp_align_accum.sv
// Self-checking bench for cim_fp_align_accum: directed corner cases plus randomized operand sets
// compared against an arithmetic reference model.
module tb_cim_fp_align_accum;
  localparam int MANT_W = 12;

  logic              clk = 1'b0;
  logic              RST;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        diff      [0:35];
  logic [3:0]        prod_sign [0:35];
  logic [MANT_W-1:0] prod_mant [0:35][0:3];
  logic [4:0]        exp_base;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_fp    [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cim_fp_align_accum #(.MANT_W(MANT_W)) dut (
    .clk(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .diff(diff), .prod_sign(prod_sign), .prod_mant(prod_mant), .exp_base(exp_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp)
  );

  // Column sum as a plain signed integer.
  function automatic longint model_col(input int c);
    longint acc = 0;
    longint t;
    for (int r = 0; r < 36; r++) begin
      t = (diff[r] >= MANT_W) ? 0 : (longint'(prod_mant[r][c]) >> diff[r]);
      acc += prod_sign[r][c] ? -t : t;
    end
    return acc;
  endfunction

  // Value-level FP16 conversion: floor(log2|acc|), scaled fraction, saturation / flush.
  function automatic logic [15:0] model_fp(input longint acc, input int eb);
    logic   s;
    longint m, frac;
    int     p, e;
    s = (acc < 0);
    m = s ? -acc : acc;
    if (m == 0) return 16'h0000;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    e = eb + p - (MANT_W - 2);
    frac = ((m << 10) >> p) - 1024;
`ifdef CIM_FP_ROUND_EN
    if ((((m << 11) >> p) & 1) != 0) frac = frac + 1;
    if (frac == 1024) begin
      frac = 0;
      e = e + 1;
    end
`endif
    if (e >= 31) return {s, 5'h1F, 10'h000};
    if (e <= 0)  return {s, 15'h0000};
    return {s, e[4:0], frac[9:0]};
  endfunction

  task automatic clear_ops();
    for (int r = 0; r < 36; r++) begin
      diff[r] = '0;
      prod_sign[r] = '0;
      for (int c = 0; c < 4; c++) prod_mant[r][c] = '0;
    end
    exp_base = 5'd15;
  endtask

  task automatic set_scn1();
    clear_ops();
    for (int r = 0; r < 36; r++) prod_mant[r][0] = 12'd1024;
  endtask

  task automatic scramble_ops();
    for (int r = 0; r < 36; r++) begin
      diff[r] = 5'($urandom);
      prod_sign[r] = 4'($urandom);
      for (int c = 0; c < 4; c++) prod_mant[r][c] = MANT_W'($urandom);
    end
    exp_base = 5'($urandom);
  endtask

  // One full transaction: accept, latency, results, optional stall in HOLD, release.
  task automatic do_txn(input string name, input logic [15:0] exp_v [0:3], input int stall);
    int n;
    logic [15:0] held [0:3];
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", name, in_ready);
    end
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    scramble_ops();
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 40) begin
      errors++;
      $display("FAIL %s latency: got %0d want 40", name, n);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_fp[c] !== exp_v[c]) begin
        errors++;
        $display("FAIL %s out_fp[%0d]: got %h want %h", name, c, out_fp[c], exp_v[c]);
      end
      held[c] = out_fp[c];
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_fp !== held) begin
        errors++;
        $display("FAIL %s hold_stall cycle %0d: out_valid=%b in_ready=%b want 1/0 and stable words",
                 name, k, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear_ops();
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_fp[c] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_out_fp[%0d]: got %h want 0000", c, out_fp[c]);
      end
    end
    RST = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] e [0:3];
    set_scn1();
    e = '{16'h5080, 16'h0000, 16'h0000, 16'h0000};
    do_txn("sum36", e, 0);

    clear_ops();
    prod_mant[0][0] = 12'd1024;
    prod_mant[1][0] = 12'd1024;
    diff[1] = 5'd1;
    prod_sign[1] = 4'b0001;
    e = '{16'h3800, 16'h0000, 16'h0000, 16'h0000};
    do_txn("half", e, 0);

    clear_ops();
    for (int r = 0; r < 36; r++) begin
      diff[r] = 5'd31;
      for (int c = 0; c < 4; c++) prod_mant[r][c] = 12'hFFF;
    end
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    do_txn("diff31", e, 0);

    set_scn1();
    exp_base = 5'd30;
    e = '{16'h7C00, 16'h0000, 16'h0000, 16'h0000};
    do_txn("overflow_inf", e, 0);

    clear_ops();
    exp_base = 5'd1;
    prod_mant[0][0] = 12'd1;
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    do_txn("flush", e, 0);

    clear_ops();
    for (int r = 0; r < 36; r++) begin
      prod_sign[r] = 4'b0010;
      prod_mant[r][1] = 12'd1024;
    end
    e = '{16'h0000, 16'hD080, 16'h0000, 16'h0000};
    do_txn("negative", e, 0);
  endtask

  task automatic test_abort();
    int n;
    set_scn1();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(posedge clk);
    #1 RST = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    RST = 1'b0;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL abort_idle: %0d cycles with out_valid=1 or in_ready=0, want 0", n);
    end
    set_scn1();
    begin
      logic [15:0] e [0:3];
      e = '{16'h5080, 16'h0000, 16'h0000, 16'h0000};
      do_txn("after_abort", e, 0);
    end
  endtask

  task automatic test_hold_stall();
    logic [15:0] e [0:3];
    set_scn1();
    e = '{16'h5080, 16'h0000, 16'h0000, 16'h0000};
    do_txn("stall5", e, 5);
  endtask

  task automatic test_random();
    logic [15:0] e [0:3];
    for (int t = 0; t < 10; t++) begin
      for (int r = 0; r < 36; r++) begin
        diff[r] = (t < 3) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 14));
        prod_sign[r] = (t == 0) ? 4'b0000 : 4'($urandom);
        for (int c = 0; c < 4; c++) prod_mant[r][c] = MANT_W'($urandom_range(0, 4095));
      end
      exp_base = 5'($urandom_range(0, 31));
      for (int c = 0; c < 4; c++) e[c] = model_fp(model_col(c), int'(exp_base));
      do_txn($sformatf("random%0d", t), e, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_hold_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
